// File: rtl/lattice_row_shifter.sv
// Row serializer: fills a WIDTH-cell row over valid/ready, then emits one cell per
// rising edge of the sampled shift clock. Macro LATTICE_ROW_SHIFTER_WRAP_EN enables row replay.
module lattice_row_shifter #(
  parameter int WIDTH      = 150,
  parameter int WIDTH_BITS = 8,
  parameter int DATA_W     = 8
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              shift_clk,
  output logic [DATA_W-1:0] cell_out,
  output logic              cell_valid,
  output logic              row_done,
  output logic              busy
);

  typedef enum logic [1:0] {FILL, ARMED, SHIFT} state_t;

  localparam logic [WIDTH_BITS:0] WIDTH_C = (WIDTH_BITS + 1)'(WIDTH);

  state_t              state_q, state_d;
  logic [WIDTH_BITS:0] cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0]   row_q [WIDTH];
  logic [DATA_W-1:0]   row_d [WIDTH];
  logic [DATA_W-1:0]   cell_out_q, cell_out_d;
  logic                cell_valid_q, cell_valid_d;
  logic                row_done_q, row_done_d;
  logic                shift_q;
  logic                shift_edge;
  logic [DATA_W-1:0]   tail_fill;

  assign shift_edge = shift_clk & ~shift_q;
  assign cnt_inc    = cnt_q + 1'b1;
  assign in_ready   = (state_q == FILL) & ~reset;
  assign busy       = (state_q != FILL);
  assign cell_out   = cell_out_q;
  assign cell_valid = cell_valid_q;
  assign row_done   = row_done_q;

`ifdef LATTICE_ROW_SHIFTER_WRAP_EN
  assign tail_fill = row_q[0];
`else
  assign tail_fill = '0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    cell_out_d   = cell_out_q;
    cell_valid_d = 1'b0;
    row_done_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (in_valid && in_ready) begin
          for (int unsigned i = 0; i < WIDTH - 1; i++) row_d[i] = row_q[i+1];
          row_d[WIDTH-1] = in_data;
          if (cnt_inc == WIDTH_C) begin
            cnt_d   = '0;
            state_d = ARMED;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ARMED, SHIFT: begin
        // ARMED always holds cnt==0, so both states share the emit path.
        if (shift_edge) begin
          cell_out_d   = row_q[0];
          cell_valid_d = 1'b1;
          for (int unsigned i = 0; i < WIDTH - 1; i++) row_d[i] = row_q[i+1];
          row_d[WIDTH-1] = tail_fill;
          if (cnt_inc == WIDTH_C) begin
            row_done_d = 1'b1;
            cnt_d      = '0;
`ifdef LATTICE_ROW_SHIFTER_WRAP_EN
            state_d    = ARMED;
`else
            state_d    = FILL;
`endif
          end else begin
            cnt_d   = cnt_inc;
            state_d = SHIFT;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) row_q[i] <= '0;
      cell_out_q   <= '0;
      cell_valid_q <= 1'b0;
      row_done_q   <= 1'b0;
      shift_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      cell_out_q   <= cell_out_d;
      cell_valid_q <= cell_valid_d;
      row_done_q   <= row_done_d;
      shift_q      <= shift_clk;
    end
  end

endmodule

// File: tb/tb_lattice_row_shifter.sv
// Scoreboard bench for lattice_row_shifter at WIDTH=4; expected cells are queued at stimulus
// time and checked by an independent monitor. Honors LATTICE_ROW_SHIFTER_WRAP_EN if defined.
module tb_lattice_row_shifter;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       shift_clk = 1'b0;
  logic [7:0] cell_out;
  logic       cell_valid;
  logic       row_done;
  logic       busy;

  lattice_row_shifter #(.WIDTH(4), .WIDTH_BITS(2), .DATA_W(8)) dut (
    .clk_in(clk_in), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .shift_clk(shift_clk), .cell_out(cell_out),
    .cell_valid(cell_valid), .row_done(row_done), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] d;
    logic       rd;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   acc_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk_in) begin
    cyc++;
    if (in_valid && in_ready) acc_cnt++;
  end

  always @(negedge clk_in) begin
    if (row_done && !cell_valid) begin
      n_vec++; n_err++;
      $display("FAIL row_done_alone: row_done=1 cell_valid=0 required cell_valid=1 at cyc %0d", cyc);
    end
    if (cell_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_cell: got cell_out=%02h row_done=%0b at cyc %0d, required no cell_valid",
                 cell_out, row_done, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cell_out !== e.d || row_done !== e.rd || cyc != e.cyc) begin
          n_err++;
          $display("FAIL cell: got %02h rd=%0b cyc=%0d, required %02h rd=%0b cyc=%0d",
                   cell_out, row_done, cyc, e.d, e.rd, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  // One shift_clk pulse held high for hi cycles; queues the expected cell when one is due.
  task automatic pulse(input int hi, input bit exp_en, input logic [7:0] d, input bit rd);
    exp_t e;
    if (exp_en) begin
      e.d = d; e.rd = rd; e.cyc = cyc + 1;
      sb.push_back(e);
    end
    shift_clk = 1'b1;
    repeat (hi) tick();
    shift_clk = 1'b0;
    tick();
  endtask

  task automatic fill(input logic [7:0] d [4], input int g [4], input bit edge_on_last);
    int a0;
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0;
      repeat (g[i]) tick();
      chk("fill_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = d[i];
      if (i == 3 && edge_on_last) shift_clk = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("armed_ready", in_ready, 0);
    chk("armed_busy", busy, 1);
    chk("accepts", acc_cnt - a0, 4);
    if (edge_on_last) begin
      repeat (2) tick();
      shift_clk = 1'b0;
      tick();
    end
  endtask

  task automatic emit_row(input logic [7:0] d [4]);
    for (int i = 0; i < 4; i++) pulse(1, 1'b1, d[i], i == 3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    chk("reset_ready", in_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_cell_out", cell_out, 0);
    chk("rst_cell_valid", cell_valid, 0);
    chk("rst_row_done", row_done, 0);
  endtask

  task automatic after_row(input logic [7:0] d [4]);
    tick();
`ifdef LATTICE_ROW_SHIFTER_WRAP_EN
    chk("wrap_ready", in_ready, 0);
    chk("wrap_busy", busy, 1);
    emit_row(d);
    chk("wrap_ready_after", in_ready, 0);
    do_reset();
`else
    chk("done_ready", in_ready, 1);
    chk("done_busy", busy, 0);
    pulse(1, 1'b0, d[0], 1'b0);
    pulse(1, 1'b0, d[0], 1'b0);
    chk("idle_ready", in_ready, 1);
`endif
  endtask

  initial begin
    logic [7:0] r1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] r2 [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] r3 [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    logic [7:0] r4 [4] = '{8'hC3, 8'h00, 8'hFF, 8'h5A};
    int g0 [4] = '{0, 0, 0, 0};
    int gs [4] = '{3, 0, 2, 1};
    int a0;

    do_reset();

    // Pulses during FILL are ignored.
    pulse(1, 1'b0, 8'h00, 1'b0);
    pulse(3, 1'b0, 8'h00, 1'b0);
    chk("fill_busy", busy, 0);

    // Basic row.
    fill(r1, g0, 1'b0);
    emit_row(r1);
    after_row(r1);

    // Stalled source, in_valid held during shift, long high shift_clk.
    fill(r2, gs, 1'b0);
    a0 = acc_cnt;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    pulse(10, 1'b1, r2[0], 1'b0);
    pulse(1, 1'b1, r2[1], 1'b0);
    pulse(2, 1'b1, r2[2], 1'b0);
    chk("shift_no_accept", acc_cnt - a0, 0);
    in_valid = 1'b0;
    pulse(1, 1'b1, r2[3], 1'b1);
    after_row(r2);

    // Reset mid-shift, then refill.
    fill(r1, g0, 1'b0);
    pulse(1, 1'b1, r1[0], 1'b0);
    pulse(1, 1'b1, r1[1], 1'b0);
    do_reset();
    fill(r3, g0, 1'b0);
    emit_row(r3);
    after_row(r3);

    // Edge coinciding with the last accept is ignored.
    fill(r4, g0, 1'b1);
    chk("coincide_busy", busy, 1);
    emit_row(r4);
    after_row(r4);

    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lattice_row_shifter.md
# lattice_row_shifter

Row serializer that sits directly downstream of the shift-clock generator in the lattice display path. It collects one row of WIDTH cells from the row source over a valid/ready stream, then emits one cell per rising edge of the generated shift clock. It flags end of row so the row source can supply the next row. Everything runs in the single `clk_in` domain; `shift_clk` is sampled, never used as a clock.

## Interface
- `WIDTH`, 150: cells per row.
- `WIDTH_BITS`, 8: index width; the cell counter is WIDTH_BITS+1 bits.
- `DATA_W`, 8: bits per cell.

Ports:
- `clk_in` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: row source has a cell.
- `in_data` in DATA_W: cell value; first accepted cell is cell 0.
- `in_ready` out 1: block accepts a cell this cycle.
- `shift_clk` in 1: shift clock from the clock generator, in the `clk_in` domain.
- `cell_out` out DATA_W: current output cell.
- `cell_valid` out 1: one-cycle strobe, `cell_out` is new.
- `row_done` out 1: one-cycle strobe with the last cell of a row.
- `busy` out 1: high in ARMED and SHIFT.

## Operation
- Storage is a WIDTH×DATA_W shift register with a head at cell 0. There is one counter `cnt`, an edge register `shift_q`, and a state register.
- **Edge detect:** `shift_q <= shift_clk` every cycle. `edge = shift_clk & ~shift_q`. Edges are acted on only in ARMED and SHIFT; they are ignored in FILL.
- **FILL (reset state):**
  - `in_ready = 1`.
  - Accept when `in_valid & in_ready`: the cell enters the tail and `cnt++`.
  - On the WIDTH-th accept, `cnt <= 0` and the state becomes ARMED.
- **ARMED:** `in_ready = 0`. On `edge`:
  - `cell_out <= head`, `cell_valid <= 1`, the buffer shifts one toward the head, and `cnt <= 1`.
  - Go to SHIFT. If WIDTH==1, apply the last-cell rule instead.
- **SHIFT:** on `edge`, emit the head as above and `cnt++`. When the emitted cell is the WIDTH-th:
  - `row_done <= 1` together with `cell_valid`, and `cnt <= 0`.
  - The next state depends on the Configuration macro.
- The fill value entering the tail during SHIFT depends on the Configuration macro.
- `in_valid` outside FILL is ignored and nothing is accepted.
- `cnt` never exceeds WIDTH. It compares against WIDTH exactly, with no modulo wrap.

## Timing
- Reset values: `cell_out = 0`, `cell_valid = 0`, `row_done = 0`, `busy = 0`, state FILL, `cnt = 0`, buffer all zero, `shift_q = 0`.
- `in_ready` is combinational, `state==FILL & ~reset`. It is therefore 0 during reset and 1 in the first cycle after reset.
- **Fill latency:** one cell per cycle at most. WIDTH accepts bring ARMED in the cycle after the last accept.
- **Output latency:** 1 cycle. If `edge` is detected in cycle n, then `cell_out`, `cell_valid` and `row_done` are registered at the end of cycle n and visible in cycle n+1.
- **Strobe widths:** `cell_valid` and `row_done` are high for exactly one cycle per edge, even if `shift_clk` stays high.
- A `shift_clk` held high or falling produces no output.
- **Edge coinciding with the last fill accept:** the edge is ignored. `shift_q` still updates, so the next output needs a fresh rising edge.
- **Reset mid-fill or mid-shift:**
  - Next cycle is FILL with `cnt = 0` and the buffer cleared.
  - Strobes are 0.
  - The next accepted cell is cell 0.

## Configuration
- Macro `LATTICE_ROW_SHIFTER_WRAP_EN`.
- **Defined:** recirculate.
  - The head cell emitted in SHIFT re-enters the tail.
  - After `row_done` the state returns to ARMED with the row intact, so the next WIDTH edges replay the same row.
  - FILL is re-entered only via reset.
- **Undefined:** zeros enter the tail during SHIFT.
  - After `row_done` the state returns to FILL, and `in_ready` rises in the cycle after the `row_done` strobe.

## Test plan
- **Basic row (WIDTH=4, DATA_W=8):** reset, then fill 0x11, 0x22, 0x33, 0x44 back-to-back, then give 4 `shift_clk` pulses.
  - `cell_out` must be 0x11, 0x22, 0x33, 0x44, each one cycle after its rising edge with `cell_valid` high.
  - `row_done` must be high only with 0x44.
- **Stalled source:** fill with `in_valid` gaps of 0–3 cycles.
  - Exactly 4 accepts must occur, then `in_ready` drops.
  - `in_valid` held high during SHIFT causes no accept.
- **Edge qualification:**
  - `shift_clk` held high 10 cycles gives a single `cell_valid`.
  - A falling edge gives nothing.
  - Pulses during FILL give no output, and `busy` stays 0.
- **Reset mid-shift:** assert reset after 2 cells.
  - Next cycle `busy=0`, `in_ready=1`, `cell_out=0`.
  - Refilling with 0xA0–0xA3 then emits 0xA0 first.
- **Wrap (macro defined):** after `row_done`, 4 more pulses with no fill.
  - Output 0x11, 0x22, 0x33, 0x44 again, with `in_ready` staying 0.
- **Wrap (macro undefined):** after `row_done`, `in_ready=1` and further pulses produce no `cell_valid` until 4 new cells are accepted.
